key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_pkg.sv | 14 +
 rtl/sync2.sv | 22 ++
 rtl/key_debounce.sv | 120 ++++++++++++
 tb/tb_key_debounce.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the push-button debouncer.
`timescale 1ns/1ps
package key_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit; both flops clear on reset.
`timescale 1ns/1ps
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronizes key1 and accepts a level change after DEBOUNCE_CYCLES
// consecutive equal samples. Define KEY_RELEASE_EN to add the key_release pulse output.
`timescale 1ns/1ps
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key1,
    output logic key_level,
`ifdef KEY_RELEASE_EN
    output logic key_press,
    output logic key_release
`else
    output logic key_press
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          key_s;
    key_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          level_next;
    logic          press_next;
`ifdef KEY_RELEASE_EN
    logic          release_next;
`endif

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key1),
        .q     (key_s)
    );

    // Outputs are registered from the next-state decode so level and pulses align with the state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
`ifdef KEY_RELEASE_EN
            key_release <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            key_level   <= level_next;
            key_press   <= press_next;
`ifdef KEY_RELEASE_EN
            key_release <= release_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
`ifdef KEY_RELEASE_EN
        release_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (key_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CW'(1);
                end else begin
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end else begin
                    cnt_next   = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!key_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CW'(1);
                end else begin
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A high sample cancels the release without any pulse.
                if (key_s) begin
                    state_next   = PRESSED;
                    cnt_next     = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
`ifdef KEY_RELEASE_EN
                    release_next = 1'b1;
`endif
                end else begin
                    cnt_next     = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random bouncing against a run-length model.
`timescale 1ns/1ps
module tb_key_debounce;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset;
    logic key1;
    logic key_level;
    logic key_press;
`ifdef KEY_RELEASE_EN
    logic key_release;
`endif

    int checks   = 0;
    int failures = 0;
    int press_count;

    // Reference model: synchronizer delay line, accepted level, run of disagreeing samples.
    logic [1:0] m_sync;
    logic       m_level;
    logic       m_press;
    logic       m_release;
    int         m_run;

    // Downstream LED toggle stage driven by the debounced press pulse.
    logic led0;

    key_debounce #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .key1        (key1),
        .key_level   (key_level),
`ifdef KEY_RELEASE_EN
        .key_press   (key_press),
        .key_release (key_release)
`else
        .key_press   (key_press)
`endif
    );

    always #10 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) led0 <= 1'b0;
        else if (key_press) led0 <= ~led0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_sync    = 2'b00;
        m_level   = 1'b0;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_run     = 0;
    endtask

    task automatic modelStep(input logic k);
        logic ks;
        ks        = m_sync[1];
        m_sync    = {m_sync[0], k};
        m_press   = 1'b0;
        m_release = 1'b0;
        if (ks != m_level) begin
            m_run++;
            if (m_run == DB) begin
                m_level = ks;
                m_run   = 0;
                if (ks) m_press = 1'b1;
                else    m_release = 1'b1;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic applyStimulus(input logic k, input string tag);
        key1 = k;
        @(posedge clk);
        modelStep(k);
        #1;
        if (key_press) press_count++;
        checkOutput({tag, ".level"}, {31'd0, key_level}, {31'd0, m_level});
        checkOutput({tag, ".press"}, {31'd0, key_press}, {31'd0, m_press});
`ifdef KEY_RELEASE_EN
        checkOutput({tag, ".release"}, {31'd0, key_release}, {31'd0, m_release});
`endif
    endtask

    task automatic applyHold(input logic k, input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(k, tag);
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("reset.level", {31'd0, key_level}, 32'd0);
        checkOutput("reset.press", {31'd0, key_press}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic lvl;
        int   len;
        reset       = 1'b0;
        key1        = 1'b0;
        press_count = 0;
        modelReset();

        doReset();

        // Clean press held long: exactly one pulse.
        press_count = 0;
        applyHold(1'b1, 12, "clean");
        checkOutput("clean.count", press_count, 32'd1);
        checkOutput("clean.hold_level", {31'd0, key_level}, 32'd1);

        applyHold(1'b0, 10, "release");
        checkOutput("release.level", {31'd0, key_level}, 32'd0);

        // Bounce: high 2 cycles / low 1 cycle three times, then settle high.
        press_count = 0;
        for (int i = 0; i < 3; i++) begin
            applyHold(1'b1, 2, "bounce");
            applyHold(1'b0, 1, "bounce");
        end
        checkOutput("bounce.nopulse", press_count, 32'd0);
        applyHold(1'b1, 10, "bounce_settle");
        checkOutput("bounce.count", press_count, 32'd1);
        applyHold(1'b0, 10, "bounce_release");

        // Short glitch of three cycles must not be accepted.
        press_count = 0;
        applyHold(1'b1, 3, "glitch");
        applyHold(1'b0, 8, "glitch");
        checkOutput("glitch.count", press_count, 32'd0);

        // Reset in the middle of a debounce with the key still held.
        applyHold(1'b1, 2, "midreset");
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("midreset.level", {31'd0, key_level}, 32'd0);
        checkOutput("midreset.press", {31'd0, key_press}, 32'd0);
`ifdef KEY_RELEASE_EN
        checkOutput("midreset.release", {31'd0, key_release}, 32'd0);
`endif
        #9;
        reset = 1'b0;
        press_count = 0;
        applyHold(1'b1, 10, "after_reset");
        checkOutput("after_reset.count", press_count, 32'd1);
        applyHold(1'b0, 10, "after_reset_rel");

        // LED toggle stage: two clean presses toggle 0 -> 1 -> 0.
        doReset();
        checkOutput("led.init", {31'd0, led0}, 32'd0);
        applyHold(1'b1, 8, "led_p1");
        checkOutput("led.first", {31'd0, led0}, 32'd1);
        applyHold(1'b0, 8, "led_r1");
        applyHold(1'b1, 8, "led_p2");
        checkOutput("led.second", {31'd0, led0}, 32'd0);
        applyHold(1'b0, 8, "led_r2");

        // Random bouncing segments around the debounce threshold.
        lvl = 1'b0;
        for (int s = 0; s < 300; s++) begin
            lvl = ~lvl;
            len = $urandom_range(1, DB + 3);
            applyHold(lvl, len, "random");
        end
        applyHold(1'b0, 8, "random_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
